hazard_fwd_ctrl: RTL and testbench

- Central hazard unit for the 5-stage pipeline (F/D/E/M/W).
- Each cycle it takes the decoded register usage of the instruction in D and tracks in-flight writers in E, M and W through its own stage registers.
- Produces the 2-bit forwarding selects consumed by the D- and E-stage operand muxes, where 0 = register value, 1 = M-stage forward, 2 = W-stage forward.
- Also produces the stall that freezes PC and the F/D register and injects a bubble into E.

---
 rtl/hazard_fwd_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
//
// Central hazard unit for a 5-stage F/D/E/M/W pipeline. It keeps its own
// shadow copy of the writer information for the instructions in E, M and W.
// From that copy it derives:
//   * the operand forwarding selects for the D- and E-stage muxes,
//     where 0 = register value, 1 = M-stage result and 2 = W-stage result.
//   * the M-stage store-data select.
//   * the stall that freezes PC and F/D and injects a bubble into E.
//
// Optional feature (macro HAZARD_MD_EN):
//   defined   : hi/lo busy counter, md_busy output and the hi/lo stall term.
//   undefined : no hi/lo tracking. md_busy is tied low and the D_md_* inputs
//               are ignored.
//
// Parameters:
//   MULT_CYCLES  busy cycles of the hi/lo unit for mult/multu
//   DIV_CYCLES   busy cycles of the hi/lo unit for div/divu
//
// Ports:
//   clk          pipeline clock, rising edge
//   reset        asynchronous, active-low reset
//   D_rs, D_rt   source register fields of the instruction in D
//   D_rs_tuse    cycles after D until rs is consumed (3 = unused)
//   D_rt_tuse    cycles after D until rt is consumed (3 = unused)
//   D_wen        instruction in D writes the GPR file
//   D_dst        destination GPR of the instruction in D
//   D_tnew       cycles after entering E until the result is at the M output
//   D_md_start   D holds mult/multu/div/divu
//   D_md_div     qualifies D_md_start: 1 = div class
//   D_md_use     D holds mfhi/mflo/mthi/mtlo
//   stall        freeze PC and F/D, bubble E
//   fwd_D_rs     D-stage rs select
//   fwd_D_rt     D-stage rt select
//   fwd_E_rs     E-stage rs select
//   fwd_E_rt     E-stage rt select
//   fwd_M_rt     M-stage store-data select (0 = register, 2 = W)
//   md_busy      hi/lo unit is computing
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] D_rs,
   input  logic [4:0] D_rt,
   input  logic [1:0] D_rs_tuse,
   input  logic [1:0] D_rt_tuse,
   input  logic       D_wen,
   input  logic [4:0] D_dst,
   input  logic [1:0] D_tnew,
   input  logic       D_md_start,
   input  logic       D_md_div,
   input  logic       D_md_use,
   output logic       stall,
   output logic [1:0] fwd_D_rs,
   output logic [1:0] fwd_D_rt,
   output logic [1:0] fwd_E_rs,
   output logic [1:0] fwd_E_rt,
   output logic [1:0] fwd_M_rt,
   output logic       md_busy
);

   // E stage
   logic       e_wen;
   logic [4:0] e_dst;
   logic [1:0] e_tnew;
   logic [4:0] e_rs;
   logic [4:0] e_rt;

   // M stage
   logic       m_wen;
   logic [4:0] m_dst;
   logic [1:0] m_tnew;
   logic [4:0] m_rt;

   // W stage
   logic       w_wen;
   logic [4:0] w_dst;

   // A stage only counts as a writer when the target is not $0.
   logic e_writing;
   logic m_writing;
   logic w_writing;

   logic hazard_stall;
   logic md_stall;

   assign e_writing = e_wen && (e_dst != '0);
   assign m_writing = m_wen && (m_dst != '0);
   assign w_writing = w_wen && (w_dst != '0);

   // A producer blocks the consumer when its result arrives later than the
   // consumer needs it.
   function automatic logic dep_hit(
      input logic [4:0] src,
      input logic [1:0] tuse,
      input logic       wr,
      input logic [4:0] dst,
      input logic [1:0] tnew
   );
      return (tuse != 2'd3) && wr && (dst == src) && (tnew > tuse);
   endfunction

   // The M stage takes priority over W because M holds the younger producer.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] src,
      input logic       m_wr,
      input logic [4:0] m_d,
      input logic [1:0] m_t,
      input logic       w_wr,
      input logic [4:0] w_d
   );
      logic [1:0] sel;
      sel = 2'd0;
      if (m_wr && (m_d == src) && (m_t == 2'd0)) begin
         sel = 2'd1;
      end else if (w_wr && (w_d == src)) begin
         sel = 2'd2;
      end
      return sel;
   endfunction

   always_comb begin
      hazard_stall = dep_hit(D_rs, D_rs_tuse, e_writing, e_dst, e_tnew)
                  || dep_hit(D_rs, D_rs_tuse, m_writing, m_dst, m_tnew)
                  || dep_hit(D_rt, D_rt_tuse, e_writing, e_dst, e_tnew)
                  || dep_hit(D_rt, D_rt_tuse, m_writing, m_dst, m_tnew);
      stall = hazard_stall || md_stall;

      fwd_D_rs = fwd_sel(D_rs, m_writing, m_dst, m_tnew, w_writing, w_dst);
      fwd_D_rt = fwd_sel(D_rt, m_writing, m_dst, m_tnew, w_writing, w_dst);
      fwd_E_rs = fwd_sel(e_rs, m_writing, m_dst, m_tnew, w_writing, w_dst);
      fwd_E_rt = fwd_sel(e_rt, m_writing, m_dst, m_tnew, w_writing, w_dst);
      fwd_M_rt = (w_writing && (w_dst == m_rt)) ? 2'd2 : 2'd0;
   end

   // Stage registers. A stall puts a bubble into E, while M and W keep
   // advancing so that older producers drain out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_wen  <= 1'b0;
         e_dst  <= '0;
         e_tnew <= '0;
         e_rs   <= '0;
         e_rt   <= '0;
         m_wen  <= 1'b0;
         m_dst  <= '0;
         m_tnew <= '0;
         m_rt   <= '0;
         w_wen  <= 1'b0;
         w_dst  <= '0;
      end else begin
         if (stall) begin
            e_wen  <= 1'b0;
            e_dst  <= '0;
            e_tnew <= '0;
            e_rs   <= '0;
            e_rt   <= '0;
         end else begin
            e_wen  <= D_wen;
            e_dst  <= D_dst;
            e_tnew <= D_tnew;
            e_rs   <= D_rs;
            e_rt   <= D_rt;
         end
         m_wen  <= e_wen;
         m_dst  <= e_dst;
         m_tnew <= (e_tnew == 2'd0) ? 2'd0 : (e_tnew - 2'd1);
         m_rt   <= e_rt;
         w_wen  <= m_wen;
         w_dst  <= m_dst;
      end
   end

`ifdef HAZARD_MD_EN
   localparam int unsigned MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int unsigned CNT_W  = (MD_MAX < 2) ? 1 : $clog2(MD_MAX + 1);

   logic             e_md_start;
   logic             e_md_div;
   logic [CNT_W-1:0] md_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_md_start <= 1'b0;
         e_md_div   <= 1'b0;
         md_cnt     <= '0;
      end else begin
         if (stall) begin
            e_md_start <= 1'b0;
            e_md_div   <= 1'b0;
         end else begin
            e_md_start <= D_md_start;
            e_md_div   <= D_md_div;
         end
         // The md stall term guarantees that the counter is idle whenever a
         // start reaches E, so a load never overrides a running count.
         if (e_md_start) begin
            md_cnt <= e_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
         end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_W'(1);
         end
      end
   end

   assign md_busy  = (md_cnt != '0);
   // A start sitting in E has not loaded the counter yet, so it must block
   // the next hi/lo instruction just like a running count.
   assign md_stall = (D_md_start || D_md_use) && (md_busy || e_md_start);
`else
   logic unused_md;

   assign unused_md = ^{D_md_start, D_md_div, D_md_use, MULT_CYCLES[0], DIV_CYCLES[0]};
   assign md_busy   = 1'b0;
   assign md_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
//
// Self-checking bench for hazard_fwd_ctrl. Each scenario task drives one
// instruction per cycle into D. When the stimulus is applied, it pushes the
// hand-derived expected output vector onto a scoreboard queue. At the falling
// edge it pops that entry and compares it against the DUT outputs.
//
// Output vector layout:
//   {stall, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt, md_busy}
//
// The bench follows the HAZARD_MD_EN macro to select the matching
// expectations for the hi/lo unit.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

   localparam int unsigned MULT_N = 5;
   localparam int unsigned DIV_N  = 10;
`ifdef HAZARD_MD_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [1:0] rs_tuse;
      logic [1:0] rt_tuse;
      logic       wen;
      logic [4:0] dst;
      logic [1:0] tnew;
      logic       md_start;
      logic       md_div;
      logic       md_use;
   } instr_t;

   typedef struct {
      instr_t      d;
      logic [11:0] v;
   } cyc_t;

   typedef struct {
      string       nm;
      int          cyc;
      logic [11:0] v;
   } sb_t;

   logic       clk;
   logic       reset;
   logic [4:0] D_rs;
   logic [4:0] D_rt;
   logic [1:0] D_rs_tuse;
   logic [1:0] D_rt_tuse;
   logic       D_wen;
   logic [4:0] D_dst;
   logic [1:0] D_tnew;
   logic       D_md_start;
   logic       D_md_div;
   logic       D_md_use;
   logic       stall;
   logic [1:0] fwd_D_rs;
   logic [1:0] fwd_D_rt;
   logic [1:0] fwd_E_rs;
   logic [1:0] fwd_E_rt;
   logic [1:0] fwd_M_rt;
   logic       md_busy;

   logic [11:0] obs;
   sb_t         sb[$];
   int          n_chk  = 0;
   int          n_fail = 0;

   localparam logic [11:0] Z = 12'd0;

   hazard_fwd_ctrl #(
      .MULT_CYCLES(MULT_N),
      .DIV_CYCLES (DIV_N)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .D_rs      (D_rs),
      .D_rt      (D_rt),
      .D_rs_tuse (D_rs_tuse),
      .D_rt_tuse (D_rt_tuse),
      .D_wen     (D_wen),
      .D_dst     (D_dst),
      .D_tnew    (D_tnew),
      .D_md_start(D_md_start),
      .D_md_div  (D_md_div),
      .D_md_use  (D_md_use),
      .stall     (stall),
      .fwd_D_rs  (fwd_D_rs),
      .fwd_D_rt  (fwd_D_rt),
      .fwd_E_rs  (fwd_E_rs),
      .fwd_E_rt  (fwd_E_rt),
      .fwd_M_rt  (fwd_M_rt),
      .md_busy   (md_busy)
   );

   assign obs = {stall, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt, md_busy};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction constructors (unused fields are zero)
   function automatic instr_t mk(input int rs, input int rt, input int rsu, input int rtu,
                                 input int wen, input int dst, input int tnew,
                                 input int ms, input int mdv, input int mu);
      instr_t i;
      i.rs       = 5'(rs);
      i.rt       = 5'(rt);
      i.rs_tuse  = 2'(rsu);
      i.rt_tuse  = 2'(rtu);
      i.wen      = 1'(wen);
      i.dst      = 5'(dst);
      i.tnew     = 2'(tnew);
      i.md_start = 1'(ms);
      i.md_div   = 1'(mdv);
      i.md_use   = 1'(mu);
      return i;
   endfunction

   function automatic instr_t nop();
      return mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic instr_t addu(input int d, input int s, input int t);
      return mk(s, t, 1, 1, 1, d, 1, 0, 0, 0);
   endfunction

   function automatic instr_t lw(input int d, input int b);
      return mk(b, 0, 1, 3, 1, d, 2, 0, 0, 0);
   endfunction

   function automatic instr_t beq(input int s, input int t);
      return mk(s, t, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic instr_t sw(input int t, input int b);
      return mk(b, t, 1, 2, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic instr_t md_op(input int s, input int t, input int dv);
      return mk(s, t, 1, 1, 0, 0, 0, 1, dv, 0);
   endfunction

   function automatic instr_t mfl(input int d);
      return mk(0, 0, 3, 3, 1, d, 1, 0, 0, 1);
   endfunction

   function automatic logic [11:0] ev(input int s, input int drs, input int drt, input int ers,
                                      input int ert, input int mrt, input int mb);
      return {1'(s), 2'(drs), 2'(drt), 2'(ers), 2'(ert), 2'(mrt), 1'(mb)};
   endfunction

   task automatic drive(input instr_t i);
      D_rs       = i.rs;
      D_rt       = i.rt;
      D_rs_tuse  = i.rs_tuse;
      D_rt_tuse  = i.rt_tuse;
      D_wen      = i.wen;
      D_dst      = i.dst;
      D_tnew     = i.tnew;
      D_md_start = i.md_start;
      D_md_div   = i.md_div;
      D_md_use   = i.md_use;
   endtask

   // Entered and left one time unit after a rising edge.
   task automatic flush();
      repeat (4) begin
         drive(nop());
         @(posedge clk);
         #1;
      end
   endtask

   // An M-stage forward is only legal when the M result is ready.
   always @(negedge clk) begin
      if (reset === 1'b1 && (fwd_E_rs == 2'd1 || fwd_E_rt == 2'd1 ||
                             fwd_D_rs == 2'd1 || fwd_D_rt == 2'd1)) begin
         n_chk++;
         if (dut.m_tnew !== 2'd0) begin
            n_fail++;
            $display("FAIL m_fwd_ready: M.tnew got %0d, required 0 when a select is 1", dut.m_tnew);
         end
      end
   end

   task automatic test_reset();
      sb_t e;
      reset = 1'b0;
      drive(nop());
      #2;
      sb.push_back('{"reset_idle", 0, Z});
      e = sb.pop_front();
      n_chk++;
      if (obs !== e.v) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", e.nm, obs, e.v);
      end
      // With the stages empty, reads cannot stall even in reset.
      drive(mk(3, 3, 0, 0, 1, 4, 2, 1, 1, 1));
      sb.push_back('{"reset_d_inputs", 0, Z});
      #1;
      e = sb.pop_front();
      n_chk++;
      if (obs !== e.v) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", e.nm, obs, e.v);
      end
      @(posedge clk);
      #1;
      sb.push_back('{"reset_held_edge", 0, Z});
      e = sb.pop_front();
      n_chk++;
      if (obs !== e.v) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", e.nm, obs, e.v);
      end
      drive(nop());
      reset = 1'b1;
   endtask

   task automatic test_alu_fwd();
      cyc_t t[$];
      sb_t  e;
      flush();
      t.push_back('{addu(1, 7, 8), Z});
      t.push_back('{addu(2, 1, 9), Z});
      t.push_back('{nop(), ev(0, 0, 0, 1, 0, 0, 0)});
      t.push_back('{nop(), Z});
      t.push_back('{addu(1, 7, 8), Z});
      t.push_back('{nop(), Z});
      t.push_back('{addu(2, 1, 9), ev(0, 1, 0, 0, 0, 0, 0)});
      t.push_back('{nop(), ev(0, 0, 0, 2, 0, 0, 0)});
      foreach (t[i]) begin
         drive(t[i].d);
         sb.push_back('{"alu_fwd", i, t[i].v});
         @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b, expected %b", e.nm, e.cyc, obs, e.v);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_load_use();
      cyc_t t[$];
      sb_t  e;
      flush();
      t.push_back('{lw(3, 10), Z});
      t.push_back('{addu(4, 5, 3), ev(1, 0, 0, 0, 0, 0, 0)});
      t.push_back('{addu(4, 5, 3), Z});
      t.push_back('{nop(), ev(0, 0, 0, 0, 2, 0, 0)});
      foreach (t[i]) begin
         drive(t[i].d);
         sb.push_back('{"load_use", i, t[i].v});
         @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b, expected %b", e.nm, e.cyc, obs, e.v);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_branch();
      cyc_t t[$];
      sb_t  e;
      flush();
      t.push_back('{lw(3, 10), Z});
      t.push_back('{beq(3, 0), ev(1, 0, 0, 0, 0, 0, 0)});
      t.push_back('{beq(3, 0), ev(1, 0, 0, 0, 0, 0, 0)});
      t.push_back('{beq(3, 0), ev(0, 2, 0, 0, 0, 0, 0)});
      t.push_back('{nop(), Z});
      t.push_back('{addu(3, 7, 8), Z});
      t.push_back('{beq(3, 0), ev(1, 0, 0, 0, 0, 0, 0)});
      t.push_back('{beq(3, 0), ev(0, 1, 0, 0, 0, 0, 0)});
      t.push_back('{nop(), ev(0, 0, 0, 2, 0, 0, 0)});
      foreach (t[i]) begin
         drive(t[i].d);
         sb.push_back('{"branch", i, t[i].v});
         @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b, expected %b", e.nm, e.cyc, obs, e.v);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_store();
      cyc_t t[$];
      sb_t  e;
      flush();
      t.push_back('{lw(6, 11), Z});
      t.push_back('{sw(6, 12), Z});
      t.push_back('{nop(), Z});
      t.push_back('{nop(), ev(0, 0, 0, 0, 0, 2, 0)});
      t.push_back('{nop(), Z});
      t.push_back('{lw(6, 11), Z});
      t.push_back('{nop(), Z});
      t.push_back('{sw(6, 12), Z});
      t.push_back('{nop(), ev(0, 0, 0, 0, 2, 0, 0)});
      t.push_back('{nop(), Z});
      foreach (t[i]) begin
         drive(t[i].d);
         sb.push_back('{"store", i, t[i].v});
         @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b, expected %b", e.nm, e.cyc, obs, e.v);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_zero_reg();
      cyc_t t[$];
      sb_t  e;
      flush();
      t.push_back('{addu(0, 7, 8), Z});
      t.push_back('{beq(0, 0), Z});
      t.push_back('{addu(9, 0, 0), Z});
      t.push_back('{lw(0, 0), Z});
      t.push_back('{addu(5, 0, 0), Z});
      t.push_back('{beq(0, 0), Z});
      t.push_back('{nop(), Z});
      foreach (t[i]) begin
         drive(t[i].d);
         sb.push_back('{"zero_reg", i, t[i].v});
         @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b, expected %b", e.nm, e.cyc, obs, e.v);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_md(input bit is_div);
      cyc_t        t[$];
      sb_t         e;
      int unsigned busy_n;
      busy_n = is_div ? DIV_N : MULT_N;
      flush();
      t.push_back('{md_op(7, 8, int'(is_div)), Z});
      if (MD_EN) begin
         t.push_back('{mfl(9), ev(1, 0, 0, 0, 0, 0, 0)});
         for (int unsigned k = 0; k < busy_n; k++) begin
            t.push_back('{mfl(9), ev(1, 0, 0, 0, 0, 0, 1)});
         end
      end
      t.push_back('{mfl(9), Z});
      t.push_back('{addu(10, 9, 0), Z});
      t.push_back('{nop(), ev(0, 0, 0, 1, 0, 0, 0)});
      foreach (t[i]) begin
         drive(t[i].d);
         sb.push_back('{is_div ? "md_div" : "md_mult", i, t[i].v});
         @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b, expected %b", e.nm, e.cyc, obs, e.v);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset_mid();
      cyc_t t[$];
      cyc_t r[$];
      sb_t  e;
      flush();
      t.push_back('{md_op(7, 8, 1), Z});
      t.push_back('{lw(3, 10), Z});
      foreach (t[i]) begin
         drive(t[i].d);
         sb.push_back('{"reset_mid_pre", i, t[i].v});
         @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b, expected %b", e.nm, e.cyc, obs, e.v);
         end
         @(posedge clk);
         #1;
      end
      // The load sits in E and the divide is counting.
      drive(addu(4, 3, 3));
      sb.push_back('{"reset_mid_busy", 2, ev(1, 0, 0, 0, 0, 0, int'(MD_EN))});
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (obs !== e.v) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %b, expected %b", e.nm, e.cyc, obs, e.v);
      end
      #2;
      reset = 1'b0;
      sb.push_back('{"reset_mid_async", 2, Z});
      #1;
      e = sb.pop_front();
      n_chk++;
      if (obs !== e.v) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %b, expected %b", e.nm, e.cyc, obs, e.v);
      end
      @(posedge clk);
      #1;
      sb.push_back('{"reset_mid_held", 3, Z});
      e = sb.pop_front();
      n_chk++;
      if (obs !== e.v) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %b, expected %b", e.nm, e.cyc, obs, e.v);
      end
      reset = 1'b1;
      r.push_back('{mfl(9), Z});
      r.push_back('{addu(1, 7, 8), Z});
      r.push_back('{addu(2, 1, 8), Z});
      r.push_back('{nop(), ev(0, 0, 0, 1, 0, 0, 0)});
      foreach (r[i]) begin
         drive(r[i].d);
         sb.push_back('{"reset_mid_post", i, r[i].v});
         @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b, expected %b", e.nm, e.cyc, obs, e.v);
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      drive(nop());
      test_reset();
      test_alu_fwd();
      test_load_use();
      test_branch();
      test_store();
      test_zero_reg();
      test_md(1'b0);
      test_md(1'b1);
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
